// File: rtl/picobello_mcast_dst_iter_pkg.sv
// rtl/picobello_mcast_dst_iter_pkg.sv - multicast field configuration, count width and FSM state types
package picobello_mcast_dst_iter_pkg;

    typedef struct packed {
        logic [7:0] offset;
        logic [7:0] len;
    } mask_sel_t;

    // Same layout as mask_sel_t so SAM mask selectors convert directly
    typedef struct packed {
        logic [7:0] offset;
        logic [7:0] len;
    } mcast_field_cfg_t;

    typedef struct packed {
        mask_sel_t mask_x;
        mask_sel_t mask_y;
    } mcast_idx_t;

    typedef struct packed {
        mcast_idx_t idx;
    } sam_rule_t;

    localparam sam_rule_t SamMcast [1] = '{
        '{idx: '{mask_x: '{offset: 8'd20, len: 8'd2},
                 mask_y: '{offset: 8'd18, len: 8'd2}}}
    };

    function automatic mcast_field_cfg_t get_mcast_field_cfg(input logic is_x);
        mcast_field_cfg_t cfg;
        if (is_x) begin
            cfg = mcast_field_cfg_t'(SamMcast[0].idx.mask_x);
        end else begin
            cfg = mcast_field_cfg_t'(SamMcast[0].idx.mask_y);
        end
        return cfg;
    endfunction

    localparam mcast_field_cfg_t McastXCfg = get_mcast_field_cfg(1'b1);
    localparam mcast_field_cfg_t McastYCfg = get_mcast_field_cfg(1'b0);

    // One extra bit so the all-ones mask count 2^(XLen+YLen) fits
    function automatic int unsigned mcast_cnt_width(input int unsigned xlen, input int unsigned ylen);
        return xlen + ylen + 1;
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } mcast_state_e;

endpackage

// File: rtl/picobello_mcast_subset_step.sv
// rtl/picobello_mcast_subset_step.sv - field pack/unpack, subset step and last detect
module picobello_mcast_subset_step
    import picobello_mcast_dst_iter_pkg::*;
#(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned XOffset   = 20,
    parameter int unsigned XLen      = 2,
    parameter int unsigned YOffset   = 18,
    parameter int unsigned YLen      = 2,
    parameter int unsigned CntWidth  = XLen + YLen + 1,
    parameter int unsigned FW        = XLen + YLen
) (
    input  logic [AddrWidth-1:0] i_req_addr,
    input  logic [AddrWidth-1:0] i_req_mask,
    output logic [FW-1:0]        o_req_base,
    output logic [FW-1:0]        o_req_m,
    output logic [CntWidth-1:0]  o_req_cnt,
    input  logic [AddrWidth-1:0] i_cur_addr,
    input  logic [FW-1:0]        i_cur_base,
    input  logic [FW-1:0]        i_cur_m,
    input  logic [FW-1:0]        i_cur_s,
    output logic [FW-1:0]        o_next_s,
    output logic                 o_last,
    output logic [AddrWidth-1:0] o_dst_addr,
    output logic [XLen-1:0]      o_dst_x,
    output logic [YLen-1:0]      o_dst_y
);

    logic [FW-1:0]       w_req_f;
    logic [FW-1:0]       w_dst_f;
    logic [CntWidth-1:0] w_pop;
    logic                w_unused_mask;

    // Mask bits outside the X/Y fields carry no meaning here
    assign w_unused_mask = ^i_req_mask;

    assign w_req_f    = {i_req_addr[XOffset +: XLen], i_req_addr[YOffset +: YLen]};
    assign o_req_m    = {i_req_mask[XOffset +: XLen], i_req_mask[YOffset +: YLen]};
    assign o_req_base = w_req_f & ~o_req_m;

    // Destination count is 2^popcount of the effective mask
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < int'(FW); i++) begin
            w_pop = w_pop + CntWidth'(o_req_m[i]);
        end
        o_req_cnt = CntWidth'(1) << w_pop;
    end

    // Filling the non-mask bits with ones lets the carry ripple only through mask bits
    assign o_next_s = ((i_cur_s | ~i_cur_m) + FW'(1)) & i_cur_m;
    assign o_last   = (i_cur_s == i_cur_m);

    assign w_dst_f = i_cur_base | i_cur_s;
    assign o_dst_x = w_dst_f[FW-1:YLen];
    assign o_dst_y = w_dst_f[YLen-1:0];

    // Re-insert the current destination into the latched address
    always_comb begin
        o_dst_addr                     = i_cur_addr;
        o_dst_addr[XOffset +: XLen]    = o_dst_x;
        o_dst_addr[YOffset +: YLen]    = o_dst_y;
    end

endmodule

// File: rtl/picobello_mcast_dst_iter.sv
// rtl/picobello_mcast_dst_iter.sv - serial expansion of a multicast request into unicast destinations
module picobello_mcast_dst_iter
    import picobello_mcast_dst_iter_pkg::*;
#(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned XOffset   = 32'(McastXCfg.offset),
    parameter int unsigned XLen      = 32'(McastXCfg.len),
    parameter int unsigned YOffset   = 32'(McastYCfg.offset),
    parameter int unsigned YLen      = 32'(McastYCfg.len),
    parameter int unsigned CntWidth  = mcast_cnt_width(XLen, YLen)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [AddrWidth-1:0] req_mask_i,
    output logic                 dst_valid_o,
    input  logic                 dst_ready_i,
    output logic [AddrWidth-1:0] dst_addr_o,
    output logic [XLen-1:0]      dst_x_o,
    output logic [YLen-1:0]      dst_y_o,
    output logic                 dst_last_o,
    output logic [CntWidth-1:0]  dst_cnt_o
);

    localparam int unsigned FW = XLen + YLen;

    if (!((XOffset + XLen <= YOffset) || (YOffset + YLen <= XOffset))) begin : g_chk_overlap
        $error("X and Y fields overlap");
    end
    if ((XOffset + XLen > AddrWidth) || (YOffset + YLen > AddrWidth)) begin : g_chk_range
        $error("X or Y field exceeds the address width");
    end

    mcast_state_e         r_state;
    mcast_state_e         w_state_next;
    logic [AddrWidth-1:0] r_addr;
    logic [FW-1:0]        r_base;
    logic [FW-1:0]        r_m;
    logic [FW-1:0]        r_s;
    logic [CntWidth-1:0]  r_cnt;

    logic [FW-1:0]        w_req_base;
    logic [FW-1:0]        w_req_m;
    logic [CntWidth-1:0]  w_req_cnt;
    logic [FW-1:0]        w_next_s;
    logic                 w_last;
    logic                 w_req_ready;
    logic                 w_dst_valid;
    logic                 w_accept;
    logic                 w_advance;

    picobello_mcast_subset_step #(
        .AddrWidth (AddrWidth),
        .XOffset   (XOffset),
        .XLen      (XLen),
        .YOffset   (YOffset),
        .YLen      (YLen),
        .CntWidth  (CntWidth),
        .FW        (FW)
    ) u_step (
        .i_req_addr (req_addr_i),
        .i_req_mask (req_mask_i),
        .o_req_base (w_req_base),
        .o_req_m    (w_req_m),
        .o_req_cnt  (w_req_cnt),
        .i_cur_addr (r_addr),
        .i_cur_base (r_base),
        .i_cur_m    (r_m),
        .i_cur_s    (r_s),
        .o_next_s   (w_next_s),
        .o_last     (w_last),
        .o_dst_addr (dst_addr_o),
        .o_dst_x    (dst_x_o),
        .o_dst_y    (dst_y_o)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_dst_valid  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid_i) begin
                    w_state_next = ST_ITER;
                end
            end
            ST_ITER: begin
                w_dst_valid = 1'b1;
                if (dst_ready_i && w_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_accept  = w_req_ready & req_valid_i;
    assign w_advance = w_dst_valid & dst_ready_i & ~w_last;

    // Request latch and subset advance; registers only move on a handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr <= '0;
            r_base <= '0;
            r_m    <= '0;
            r_s    <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_addr <= req_addr_i;
            r_base <= w_req_base;
            r_m    <= w_req_m;
            r_s    <= '0;
            r_cnt  <= w_req_cnt;
        end else if (w_advance) begin
            r_s    <= w_next_s;
        end
    end

    assign req_ready_o = w_req_ready;
    assign dst_valid_o = w_dst_valid;
    assign dst_last_o  = w_dst_valid & w_last;
    assign dst_cnt_o   = r_cnt;

endmodule
